// File: rtl/riscv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control path: the main
// controller state encoding, the base opcodes it recognises, the 3-bit
// ALU_Op codes handed to the ALU control decoder, and the ALU operand
// select codes.
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_BRANCH = 3'd6
   } ctrl_state_t;

   // instruction[6:0] opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALU_Op codes consumed by the ALU control decoder
   localparam logic [2:0] ALU_OP_R      = 3'b000;
   localparam logic [2:0] ALU_OP_I      = 3'b001;
   localparam logic [2:0] ALU_OP_LUI    = 3'b010;
   localparam logic [2:0] ALU_OP_ADD    = 3'b011;
   localparam logic [2:0] ALU_OP_BRANCH = 3'b100;

   // ALU operand A select
   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_REG    = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;

   // Opcodes that take the EXEC path out of DECODE
   function automatic logic is_exec_opcode(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle RISC-V datapath. Sequences each
// instruction through FETCH, DECODE, EXEC, MEM, WB (or BRANCH) and drives
// the datapath enables, mux selects and the ALU_Op code.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset (returns to INIT)
//   opcode_i        instruction[6:0] from the instruction register
//   mem_ready_i     memory finished the current access this cycle
//   branch_taken_i  ALU compare result, meaningful in BRANCH
//   ALU_Op_o        ALU operation class for the ALU control decoder
//   alu_src_a_o     ALU A select (PC / old PC / register A)
//   alu_src_b_o     ALU B select (register B / 4 / immediate)
//   pc_src_o        PC source (0 ALU result, 1 ALUOut)
//   pc_write_o      PC write enable
//   ir_write_o      instruction register write enable
//   mem_read_o      memory read request
//   mem_write_o     memory write request (level, held until ready)
//   reg_write_o     register file write enable
//   i_or_d_o        memory address select (0 PC, 1 ALUOut)
//   mem_to_reg_o    write-back data select (0 ALUOut, 1 memory data)
//   illegal_o       one-cycle pulse in DECODE on an unsupported opcode
//
// Parameters:
//   RESET_PC_WRITE  when 1, pc_write_o pulses in INIT to load the reset vector
// ----------------------------------------------------------------------------
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned RESET_PC_WRITE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       branch_taken_i,
   output logic [2:0] ALU_Op_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic       pc_src_o,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic       i_or_d_o,
   output logic       mem_to_reg_o,
   output logic       illegal_o
);

   ctrl_state_t state_q;
   ctrl_state_t state_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_next;
      end
   end

   // Moore decode of the state register; only the FETCH write enables and
   // the BRANCH PC write are qualified by inputs. The opcode is read straight
   // from the IR, which holds steady from DECODE until the next fetch.
   always_comb begin
      state_next   = state_q;
      ALU_Op_o     = ALU_OP_R;
      alu_src_a_o  = SRC_A_PC;
      alu_src_b_o  = SRC_B_REG;
      pc_src_o     = 1'b0;
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      mem_to_reg_o = 1'b0;
      illegal_o    = 1'b0;

      case (state_q)
         ST_INIT: begin
            // Gated by reset so the reset-vector load happens only once
            // reset has been released, never while it is held.
            pc_write_o = (RESET_PC_WRITE != 0) && !reset;
            state_next = ST_FETCH;
         end

         ST_FETCH: begin
            mem_read_o  = 1'b1;
            i_or_d_o    = 1'b0;
            alu_src_a_o = SRC_A_PC;
            alu_src_b_o = SRC_B_FOUR;
            ALU_Op_o    = ALU_OP_ADD;
            pc_src_o    = 1'b0;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
            if (mem_ready_i) begin
               state_next = ST_DECODE;
            end
         end

         ST_DECODE: begin
            // Branch target is computed here and captured in ALUOut.
            alu_src_a_o = SRC_A_OLD_PC;
            alu_src_b_o = SRC_B_IMM;
            ALU_Op_o    = ALU_OP_ADD;
            if (is_exec_opcode(opcode_i)) begin
               state_next = ST_EXEC;
            end else if (opcode_i == OP_BRANCH) begin
               state_next = ST_BRANCH;
            end else begin
               illegal_o  = 1'b1;
               state_next = ST_FETCH;
            end
         end

         ST_EXEC: begin
            case (opcode_i)
               OP_R: begin
                  alu_src_a_o = SRC_A_REG;
                  alu_src_b_o = SRC_B_REG;
                  ALU_Op_o    = ALU_OP_R;
               end
               OP_I: begin
                  alu_src_a_o = SRC_A_REG;
                  alu_src_b_o = SRC_B_IMM;
                  ALU_Op_o    = ALU_OP_I;
               end
               OP_LUI: begin
                  alu_src_b_o = SRC_B_IMM;
                  ALU_Op_o    = ALU_OP_LUI;
               end
               OP_LW, OP_SW: begin
                  alu_src_a_o = SRC_A_REG;
                  alu_src_b_o = SRC_B_IMM;
                  ALU_Op_o    = ALU_OP_ADD;
               end
               default: begin
               end
            endcase
            if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_WB;
            end
         end

         ST_MEM: begin
            i_or_d_o    = 1'b1;
            mem_read_o  = (opcode_i == OP_LW);
            mem_write_o = (opcode_i == OP_SW);
            if (mem_ready_i) begin
               state_next = (opcode_i == OP_LW) ? ST_WB : ST_FETCH;
            end
         end

         ST_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = (opcode_i == OP_LW);
            state_next   = ST_FETCH;
         end

         ST_BRANCH: begin
            alu_src_a_o = SRC_A_REG;
            alu_src_b_o = SRC_B_REG;
            ALU_Op_o    = ALU_OP_BRANCH;
            pc_src_o    = 1'b1;
            pc_write_o  = branch_taken_i;
            state_next  = ST_FETCH;
         end

         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Outputs are packed into one 16-bit
// signature per cycle:
//   [15:13] ALU_Op  [12:11] src_a  [10:9] src_b  [8] pc_src  [7] pc_write
//   [6] ir_write [5] mem_read [4] mem_write [3] reg_write [2] i_or_d
//   [1] mem_to_reg [0] illegal
// Reference signatures:
//   INIT 0000, FETCH ready 62E0, FETCH stall 6220, DECODE 6C00 (illegal 6C01)
//   EXEC R 1000, I 3400, LUI 4400, LW/SW 7400
//   MEM LW 0024, SW 0014, WB R 0008, WB LW 000A, BRANCH taken 9180 / not 9100
// ----------------------------------------------------------------------------
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [6:0] opcode_i;
   logic       mem_ready_i;
   logic       branch_taken_i;
   logic [2:0] ALU_Op_o;
   logic [1:0] alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic       pc_src_o;
   logic       pc_write_o;
   logic       ir_write_o;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       reg_write_o;
   logic       i_or_d_o;
   logic       mem_to_reg_o;
   logic       illegal_o;

   int checks;
   int failures;

   logic [15:0] obs;
   assign obs = {ALU_Op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o,
                 ir_write_o, mem_read_o, mem_write_o, reg_write_o, i_or_d_o,
                 mem_to_reg_o, illegal_o};

   multicycle_control #(.RESET_PC_WRITE(0)) dut (
      .clk            (clk),
      .reset          (reset),
      .opcode_i       (opcode_i),
      .mem_ready_i    (mem_ready_i),
      .branch_taken_i (branch_taken_i),
      .ALU_Op_o       (ALU_Op_o),
      .alu_src_a_o    (alu_src_a_o),
      .alu_src_b_o    (alu_src_b_o),
      .pc_src_o       (pc_src_o),
      .pc_write_o     (pc_write_o),
      .ir_write_o     (ir_write_o),
      .mem_read_o     (mem_read_o),
      .mem_write_o    (mem_write_o),
      .reg_write_o    (reg_write_o),
      .i_or_d_o       (i_or_d_o),
      .mem_to_reg_o   (mem_to_reg_o),
      .illegal_o      (illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each cycle: drive inputs 1 after the edge, sample 1 later, then advance.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      opcode_i = 7'b0110011;
      mem_ready_i = 1'b1;
      branch_taken_i = 1'b0;
      repeat (2) next_cycle();
      #1;
      checks++;
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_hold: got %h expected %h", obs, 16'h0000);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_init: got %h expected %h", obs, 16'h0000);
      end
      next_cycle();
      #1;
      checks++;
      if (obs !== 16'h62E0) begin
         failures++;
         $display("FAIL reset_first_fetch: got %h expected %h", obs, 16'h62E0);
      end
   endtask

   // Entered at FETCH, 1 after the edge; leaves the DUT in FETCH.
   task automatic test_add();
      logic [15:0] e [5];
      e = '{16'h62E0, 16'h6C00, 16'h1000, 16'h0008, 16'h62E0};
      opcode_i = 7'b0110011;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL add cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 4) next_cycle();
      end
   endtask

   task automatic test_i_and_lui();
      logic [15:0] e [5];
      e = '{16'h62E0, 16'h6C00, 16'h3400, 16'h0008, 16'h62E0};
      opcode_i = 7'b0010011;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL addi cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 4) next_cycle();
      end
      e = '{16'h62E0, 16'h6C00, 16'h4400, 16'h0008, 16'h62E0};
      opcode_i = 7'b0110111;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL lui cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 4) next_cycle();
      end
   endtask

   // LW with one wait state in MEM: F D E M M W then FETCH.
   task automatic test_lw_wait();
      logic [15:0] e [7];
      logic        rdy [7];
      e   = '{16'h62E0, 16'h6C00, 16'h7400, 16'h0024, 16'h0024, 16'h000A, 16'h62E0};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      opcode_i = 7'b0000011;
      for (int i = 0; i < 7; i++) begin
         mem_ready_i = rdy[i];
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 6) next_cycle();
      end
   endtask

   task automatic test_sw();
      logic [15:0] e [5];
      e = '{16'h62E0, 16'h6C00, 16'h7400, 16'h0014, 16'h62E0};
      opcode_i = 7'b0100011;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL sw cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 4) next_cycle();
      end
   endtask

   task automatic test_branch();
      logic [15:0] e [4];
      opcode_i = 7'b1100011;
      mem_ready_i = 1'b1;
      branch_taken_i = 1'b1;
      e = '{16'h62E0, 16'h6C00, 16'h9180, 16'h62E0};
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL beq_taken cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 3) next_cycle();
      end
      branch_taken_i = 1'b0;
      e = '{16'h62E0, 16'h6C00, 16'h9100, 16'h62E0};
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL beq_not_taken cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 3) next_cycle();
      end
   endtask

   task automatic test_illegal();
      logic [15:0] e [4];
      e = '{16'h62E0, 16'h6C01, 16'h62E0, 16'h6C01};
      opcode_i = 7'b1101111;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 3) next_cycle();
      end
      next_cycle();
   endtask

   // Three stall cycles in FETCH, then ready: enables only on the 4th.
   task automatic test_fetch_stall();
      logic [15:0] e [6];
      logic        rdy [6];
      e   = '{16'h6220, 16'h6220, 16'h6220, 16'h62E0, 16'h6C00, 16'h1000};
      rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      opcode_i = 7'b0110011;
      for (int i = 0; i < 6; i++) begin
         mem_ready_i = rdy[i];
         #1;
         checks++;
         if (obs !== e[i]) begin
            failures++;
            $display("FAIL fetch_stall cycle %0d: got %h expected %h", i, obs, e[i]);
         end
         if (i < 5) next_cycle();
      end
      next_cycle();
      next_cycle();
   endtask

   // Reset asserted between edges in FETCH, and again in MEM of a stalled SW.
   task automatic test_reset_mid();
      opcode_i = 7'b0110011;
      mem_ready_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid_fetch: got %h expected %h", obs, 16'h0000);
      end
      next_cycle();
      reset = 1'b0;
      mem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid_init: got %h expected %h", obs, 16'h0000);
      end
      next_cycle();
      #1;
      checks++;
      if (obs !== 16'h62E0) begin
         failures++;
         $display("FAIL reset_mid_refetch: got %h expected %h", obs, 16'h62E0);
      end
      opcode_i = 7'b0100011;
      repeat (3) next_cycle();
      mem_ready_i = 1'b0;
      #1;
      checks++;
      if (obs !== 16'h0014) begin
         failures++;
         $display("FAIL reset_mid_sw_mem: got %h expected %h", obs, 16'h0014);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid_sw_drop: got %h expected %h", obs, 16'h0000);
      end
      next_cycle();
      reset = 1'b0;
      mem_ready_i = 1'b1;
      next_cycle();
      #1;
      checks++;
      if (obs !== 16'h62E0) begin
         failures++;
         $display("FAIL reset_mid_sw_refetch: got %h expected %h", obs, 16'h62E0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_add();
      test_i_and_lui();
      test_lw_wait();
      test_sw();
      test_branch();
      test_illegal();
      test_fetch_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
